// File: rtl/audio_pkg.sv
// Shared types and widths for the I2S codec port: the default sample width,
// the RX state encoding and the bit-counter width.
package audio_pkg;

    localparam int DEF_DATA_W = 24;

    function automatic int cnt_w(input int dw);
        return $clog2(dw + 1);
    endfunction

    localparam int CNT_W = cnt_w(DEF_DATA_W);

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        SKIP      = 2'd1,
        SHIFT     = 2'd2,
        PAD       = 2'd3
    } rx_state_e;

endpackage

// File: rtl/i2s_edge_sync.sv
// Multi-stage synchroniser for one codec clock line, with single-cycle
// rise/fall strobes generated from the synchronised level.
module i2s_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2s_codec_port.sv
// I2S port in the CLOCK_50 domain: ADC deserialiser and DAC serialiser with a
// one-entry holding register. Define I2S_LOOPBACK_EN to feed ADC samples to the DAC.
module i2s_codec_port
    import audio_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              AUD_BCLK,
    input  logic              AUD_ADCLRCK,
    input  logic              AUD_ADCDAT,
    input  logic              AUD_DACLRCK,
    output logic              AUD_DACDAT,
    output logic [DATA_W-1:0] adc_left,
    output logic [DATA_W-1:0] adc_right,
    output logic              adc_valid,
    input  logic [DATA_W-1:0] dac_left,
    input  logic [DATA_W-1:0] dac_right,
    input  logic              dac_valid,
    output logic              dac_ready,
    output logic              dac_underrun,
    output logic [1:0]        rx_state_dbg
);

    localparam int            CW       = cnt_w(DATA_W);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);

    logic bclk_lvl, bclk_rise, bclk_fall;
    logic adc_lr, adc_lr_rise, adc_lr_fall;
    logic dac_lr, dac_lr_rise, dac_lr_fall;
    logic unused_strobes;

    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk(CLOCK), .rst_n(RESET), .din(AUD_BCLK),
        .level(bclk_lvl), .rise(bclk_rise), .fall(bclk_fall));
    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_adclrck_sync (
        .clk(CLOCK), .rst_n(RESET), .din(AUD_ADCLRCK),
        .level(adc_lr), .rise(adc_lr_rise), .fall(adc_lr_fall));
    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_daclrck_sync (
        .clk(CLOCK), .rst_n(RESET), .din(AUD_DACLRCK),
        .level(dac_lr), .rise(dac_lr_rise), .fall(dac_lr_fall));

    // LRCK levels are compared at BCLK edges instead of using their own strobes.
    assign unused_strobes = ^{bclk_lvl, adc_lr_rise, adc_lr_fall, dac_lr_rise, dac_lr_fall};

    // Data line gets the same depth as BCLK so bits line up with the bclk_rise strobe.
    logic [SYNC_STAGES-1:0] adcdat_sync_q, adcdat_sync_d;
    logic                   adc_dat;
    assign adc_dat = adcdat_sync_q[SYNC_STAGES-1];

    rx_state_e         rx_state_q, rx_state_d;
    logic              rx_chan_q, rx_chan_d, rx_lr_q, rx_lr_d, rx_primed_q, rx_primed_d;
    logic              have_left_q, have_left_d, pair_done_q, pair_done_d;
    logic              adc_valid_q, adc_valid_d, word_end;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d, rx_bit_idx;
    logic [DATA_W-1:0] left_shift_q, left_shift_d, right_shift_q, right_shift_d;
    logic [DATA_W-1:0] adc_left_q, adc_left_d, adc_right_q, adc_right_d;

    logic              tx_lr_q, tx_lr_d, tx_primed_q, tx_primed_d, dacdat_q, dacdat_d;
    logic              underrun_q, underrun_d, hold_full_q, hold_full_d, tx_load, accept;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d, tx_right_q, tx_right_d;
    logic [DATA_W-1:0] hold_left_q, hold_left_d, hold_right_q, hold_right_d;
    logic [DATA_W-1:0] load_left, load_right;
    logic              load_empty;

`ifdef I2S_LOOPBACK_EN
    assign load_left  = adc_left_q;
    assign load_right = adc_right_q;
    assign load_empty = 1'b0;
    assign dac_ready  = 1'b0;
`else
    assign load_left  = hold_full_q ? hold_left_q  : '0;
    assign load_right = hold_full_q ? hold_right_q : '0;
    assign load_empty = ~hold_full_q;
    assign dac_ready  = ~hold_full_q;
`endif

    assign rx_bit_idx = rx_cnt_q - CW'(1);

    always_comb begin
        adcdat_sync_d = {adcdat_sync_q[SYNC_STAGES-2:0], AUD_ADCDAT};
        rx_state_d    = rx_state_q;
        rx_chan_d     = rx_chan_q;
        rx_cnt_d      = rx_cnt_q;
        rx_lr_d       = rx_lr_q;
        rx_primed_d   = rx_primed_q;
        left_shift_d  = left_shift_q;
        right_shift_d = right_shift_q;
        have_left_d   = have_left_q;
        adc_left_d    = adc_left_q;
        adc_right_d   = adc_right_q;
        pair_done_d   = 1'b0;
        adc_valid_d   = pair_done_q;
        word_end      = 1'b0;
        if (bclk_rise) begin
            rx_lr_d     = adc_lr;
            rx_primed_d = 1'b1;
            if (rx_primed_q && (adc_lr != rx_lr_q)) begin
                // Cut-short words still count; they are left-aligned by construction.
                word_end   = (rx_state_q == SHIFT);
                rx_state_d = SKIP;
                rx_chan_d  = adc_lr;
                rx_cnt_d   = CNT_FULL;
                if (adc_lr) right_shift_d = '0;
                else        left_shift_d  = '0;
            end else if ((rx_state_q == SKIP || rx_state_q == SHIFT) && rx_cnt_q != '0) begin
                if (rx_chan_q) right_shift_d[rx_bit_idx] = adc_dat;
                else           left_shift_d[rx_bit_idx]  = adc_dat;
                rx_cnt_d   = rx_bit_idx;
                rx_state_d = (rx_cnt_q == CW'(1)) ? PAD : SHIFT;
                word_end   = (rx_cnt_q == CW'(1));
            end
        end
        if (word_end) begin
            if (!rx_chan_q) begin
                have_left_d = 1'b1;
            end else if (have_left_q) begin
                adc_left_d  = left_shift_q;
                adc_right_d = right_shift_d;
                pair_done_d = 1'b1;
            end
        end
    end

    always_comb begin
        tx_lr_d      = tx_lr_q;
        tx_primed_d  = tx_primed_q;
        tx_cnt_d     = tx_cnt_q;
        tx_shift_d   = tx_shift_q;
        tx_right_d   = tx_right_q;
        dacdat_d     = dacdat_q;
        underrun_d   = 1'b0;
        tx_load      = 1'b0;
        hold_full_d  = hold_full_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;
        if (bclk_fall) begin
            tx_lr_d     = dac_lr;
            tx_primed_d = 1'b1;
            if (tx_primed_q && (dac_lr != tx_lr_q)) begin
                tx_cnt_d = CNT_FULL;
                if (!dac_lr) begin
                    tx_load    = 1'b1;
                    tx_shift_d = load_left;
                    tx_right_d = load_right;
                    underrun_d = load_empty;
                end else begin
                    tx_shift_d = tx_right_q;
                end
            end else if (tx_cnt_q != '0) begin
                dacdat_d   = tx_shift_q[DATA_W-1];
                tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                tx_cnt_d   = tx_cnt_q - CW'(1);
            end else begin
                dacdat_d = 1'b0;
            end
        end
        // Accept wins over load, so a pair offered on the load cycle is kept.
        accept = dac_valid & dac_ready;
        if (tx_load) hold_full_d = 1'b0;
        if (accept) begin
            hold_full_d  = 1'b1;
            hold_left_d  = dac_left;
            hold_right_d = dac_right;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            adcdat_sync_q <= '0;
            rx_state_q    <= WAIT_EDGE;
            rx_chan_q     <= 1'b0;
            rx_cnt_q      <= '0;
            rx_lr_q       <= 1'b0;
            rx_primed_q   <= 1'b0;
            left_shift_q  <= '0;
            right_shift_q <= '0;
            have_left_q   <= 1'b0;
            adc_left_q    <= '0;
            adc_right_q   <= '0;
            pair_done_q   <= 1'b0;
            adc_valid_q   <= 1'b0;
            tx_lr_q       <= 1'b0;
            tx_primed_q   <= 1'b0;
            tx_cnt_q      <= '0;
            tx_shift_q    <= '0;
            tx_right_q    <= '0;
            dacdat_q      <= 1'b0;
            underrun_q    <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_left_q   <= '0;
            hold_right_q  <= '0;
        end else begin
            adcdat_sync_q <= adcdat_sync_d;
            rx_state_q    <= rx_state_d;
            rx_chan_q     <= rx_chan_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_lr_q       <= rx_lr_d;
            rx_primed_q   <= rx_primed_d;
            left_shift_q  <= left_shift_d;
            right_shift_q <= right_shift_d;
            have_left_q   <= have_left_d;
            adc_left_q    <= adc_left_d;
            adc_right_q   <= adc_right_d;
            pair_done_q   <= pair_done_d;
            adc_valid_q   <= adc_valid_d;
            tx_lr_q       <= tx_lr_d;
            tx_primed_q   <= tx_primed_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_shift_q    <= tx_shift_d;
            tx_right_q    <= tx_right_d;
            dacdat_q      <= dacdat_d;
            underrun_q    <= underrun_d;
            hold_full_q   <= hold_full_d;
            hold_left_q   <= hold_left_d;
            hold_right_q  <= hold_right_d;
        end
    end

    assign AUD_DACDAT   = dacdat_q;
    assign adc_left     = adc_left_q;
    assign adc_right    = adc_right_q;
    assign adc_valid    = adc_valid_q;
    assign dac_underrun = underrun_q;
    assign rx_state_dbg = rx_state_q;

endmodule
